// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised rx, start-glitch rejection, mid-bit sampling.
// One-cycle rx_valid per good frame one clock after the stop sample; frame_err instead if the stop bit reads 0.
module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_TICKS = CLOCK_FREQ / BAUD;
  localparam int HALF_TICKS = BAUD_TICKS / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2;
  logic        w_rx_s;
  logic [15:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [15:0] w_limit;
  logic        w_sample;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_rx_data, w_rx_data_nxt;
  logic        r_rx_valid, w_rx_valid_nxt;
  logic        r_frame_err, w_frame_err_nxt;

  assign w_rx_s   = r_sync2;
  // The start bit is sampled half a period in so every later sample lands mid-bit.
  assign w_limit  = (r_state == S_START) ? 16'(HALF_TICKS) : 16'(BAUD_TICKS);
  assign w_sample = (r_baud_cnt == w_limit - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_baud_cnt  <= w_baud_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_baud_cnt_nxt  = '0;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        w_baud_cnt_nxt = w_sample ? 16'd0 : r_baud_cnt + 16'd1;
        if (w_sample) begin
          if (!w_rx_s) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        w_baud_cnt_nxt = w_sample ? 16'd0 : r_baud_cnt + 16'd1;
        if (w_sample) begin
          w_shift_nxt   = {w_rx_s, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_baud_cnt_nxt = w_sample ? 16'd0 : r_baud_cnt + 16'd1;
        if (w_sample) begin
          if (w_rx_s) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_uart_rx;
  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
  localparam int BT = CF / BR;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLOCK_FREQ(CF), .BAUD(BR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp      = 0;
  int         n_bad      = 0;
  int         cyc        = 0;
  int         last_pulse = 0;
  int         busy_wait  = 0;
  logic [7:0] last_good  = 8'h00;
  logic [7:0] abort_byte = 8'hC3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input int gap);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    e.gap    = gap;
    exp_q.push_back(e);
    last_good = b;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    e.gap    = -1;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy_wait > 0) begin
      if (!busy || busy_wait == 1) begin
        check("busy_drop", {31'd0, busy}, 32'd0);
        busy_wait = 0;
      end else begin
        busy_wait--;
      end
    end
    if (rst_n && (rx_valid || frame_err)) begin
      check("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        if (e.gap >= 0) check("pulse_gap", cyc - last_pulse, e.gap);
        if (rx_valid) busy_wait = 2;
      end
      last_pulse = cyc;
    end
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    expect_byte(8'hA5, -1);
    send_frame(8'hA5, 1'b1);
    tick(20);

    expect_byte(8'h00, -1);
    expect_byte(8'hFF, 100);
    expect_byte(8'h55, 100);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    tick(20);

    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    expect_byte(8'h3C, -1);
    send_frame(8'h3C, 1'b1);
    tick(20);

    expect_err();
    send_frame(8'h3C, 1'b0);
    tick(20);
    check("hold_after_err", {24'd0, rx_data}, {24'd0, last_good});
    expect_byte(8'h81, -1);
    send_frame(8'h81, 1'b1);
    tick(20);

    expect_err();
    rx = 1'b0;
    tick(400);
    check("break_busy_400", {31'd0, busy}, 32'd1);
    tick(100);
    check("break_busy_500", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick(5);
    check("break_release_busy", {31'd0, busy}, 32'd0);
    check("hold_after_break", {24'd0, rx_data}, 32'h81);
    tick(20);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(abort_byte[i]);
    rx = abort_byte[4];
    tick(5);
    rst_n = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(2);
    check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n     = 1'b1;
    last_good = 8'h00;
    tick(20);
    expect_byte(8'h7E, -1);
    send_frame(8'h7E, 1'b1);
    tick(30);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
